// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_cfg
//  Description : Parametrised UART transmitter. Each accepted trmt strobe
//                sends one frame: start, data (LSB first), optional parity
//                and one or two stop bits. All outputs are driven from flops.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int CNT_W      = 12,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trmt,
    input  logic [DATA_W-1:0] tx_data,
    output logic              TX,
    output logic              busy,
    output logic              tx_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       c_DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]       c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             c_PAR_ODD   = (PARITY_ODD != 0);
    localparam logic             c_PAR_EN    = (PARITY_EN != 0);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_baud,  w_baud_nxt;
    logic [3:0]        r_bit,   w_bit_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_parity, w_parity_nxt;
    logic              r_tx,     w_tx_nxt;
    logic              r_busy,   w_busy_nxt;
    logic              r_done,   w_done_nxt;
    logic              w_baud_end;

    assign w_baud_end = (r_baud == c_BAUD_LAST);

    assign TX      = r_tx;
    assign busy    = r_busy;
    assign tx_done = r_done;

    // State and datapath registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state logic; the next TX level is computed here so the line comes from a flop.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_tx_nxt     = r_tx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (trmt) begin
                    w_shift_nxt  = tx_data;
                    w_parity_nxt = (^tx_data) ^ c_PAR_ODD;
                    w_tx_nxt     = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_done_nxt   = 1'b0;
                    w_state_nxt  = S_START;
                end
            end

            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    // Fill with ones so the register drains back to its idle pattern.
                    w_shift_nxt = {1'b1, r_shift[DATA_W-1:1]};
                    if (r_bit == c_DATA_LAST) begin
                        w_bit_nxt = '0;
                        if (c_PAR_EN) begin
                            w_tx_nxt    = r_parity;
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                        w_tx_nxt  = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            S_PARITY: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == c_STOP_LAST) begin
                        w_bit_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_cfg
//  Description : Self-checking bench for uart_tx_cfg. Three instances with
//                different framing share clock and reset; a frame-level model
//                predicts TX/busy/tx_done every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       trmt0 = 1'b0, trmt1 = 1'b0, trmt2 = 1'b0;
    logic [7:0] d0 = '0;
    logic [6:0] d1 = '0, d2 = '0;
    logic       tx0, tx1, tx2, b0, b1, b2, dn0, dn1, dn2;

    uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(16), .CNT_W(12), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .trmt(trmt0), .tx_data(d0), .TX(tx0), .busy(b0), .tx_done(dn0));
    uart_tx_cfg #(.DATA_W(7), .BAUD_DIV(8), .CNT_W(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .trmt(trmt1), .tx_data(d1), .TX(tx1), .busy(b1), .tx_done(dn1));
    uart_tx_cfg #(.DATA_W(7), .BAUD_DIV(8), .CNT_W(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .trmt(trmt2), .tx_data(d2), .TX(tx2), .busy(b2), .tx_done(dn2));

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int bd_a[3]   = '{16, 8, 8};
    int dw_a[3]   = '{8, 7, 7};
    int pen_a[3]  = '{0, 1, 1};
    int podd_a[3] = '{0, 0, 1};
    int sb_a[3]   = '{1, 2, 2};

    // Frame-level model: a bit list per instance and a cycle position inside it.
    bit m_busy[3];
    bit m_done[3];
    int m_pos[3];
    int m_nbits[3];
    bit m_frame[3][16];

    function automatic logic get_trmt(int id);
        case (id) 0: return trmt0; 1: return trmt1; default: return trmt2; endcase
    endfunction
    function automatic logic [8:0] get_data(int id);
        case (id) 0: return {1'b0, d0}; 1: return {2'b0, d1}; default: return {2'b0, d2}; endcase
    endfunction
    function automatic logic get_tx(int id);
        case (id) 0: return tx0; 1: return tx1; default: return tx2; endcase
    endfunction
    function automatic logic get_busy(int id);
        case (id) 0: return b0; 1: return b1; default: return b2; endcase
    endfunction
    function automatic logic get_done(int id);
        case (id) 0: return dn0; 1: return dn1; default: return dn2; endcase
    endfunction

    task automatic set_in(input int id, input logic t, input logic [8:0] d);
        case (id)
            0: begin trmt0 = t; d0 = d[7:0]; end
            1: begin trmt1 = t; d1 = d[6:0]; end
            default: begin trmt2 = t; d2 = d[6:0]; end
        endcase
    endtask

    task automatic model_accept(input int id, input logic [8:0] d);
        int n;
        bit p;
        p = (podd_a[id] != 0);
        m_frame[id][0] = 1'b0;
        for (int i = 0; i < dw_a[id]; i++) begin
            m_frame[id][1+i] = d[i];
            p ^= d[i];
        end
        n = 1 + dw_a[id];
        if (pen_a[id] != 0) begin
            m_frame[id][n] = p;
            n++;
        end
        for (int s = 0; s < sb_a[id]; s++) begin
            m_frame[id][n] = 1'b1;
            n++;
        end
        m_nbits[id] = n;
        m_pos[id]   = 0;
        m_busy[id]  = 1'b1;
        m_done[id]  = 1'b0;
    endtask

    function automatic logic exp_tx(int id);
        if (!m_busy[id]) return 1'b1;
        return m_frame[id][m_pos[id] / bd_a[id]];
    endfunction

    // Advance the model on every clock edge, reset asynchronously.
    always @(posedge clk or posedge rst) begin
        for (int id = 0; id < 3; id++) begin
            if (rst) begin
                m_busy[id] = 1'b0;
                m_done[id] = 1'b0;
                m_pos[id]  = 0;
            end else if (!m_busy[id]) begin
                if (get_trmt(id)) model_accept(id, get_data(id));
            end else begin
                m_pos[id]++;
                if (m_pos[id] == m_nbits[id] * bd_a[id]) begin
                    m_busy[id] = 1'b0;
                    m_done[id] = 1'b1;
                end
            end
        end
    end

    task automatic check_bit(input string name, input int id, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %b, expected %b at %0t", name, id, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int id = 0; id < 3; id++) begin
                check_bit("tx", id, get_tx(id), exp_tx(id));
                check_bit("busy", id, get_busy(id), m_busy[id]);
                check_bit("tx_done", id, get_done(id), m_done[id]);
            end
        end
    end

    // Send one frame and collect the mid-bit TX samples plus tx_done latency.
    task automatic run_frame(input int id, input logic [8:0] d, input int nbits,
                             input logic [15:0] expbits, input int explen, input bit disturb);
        logic [15:0] got;
        logic [15:0] mask;
        int rise, busy_low, bd;
        bd = bd_a[id];
        got = '0;
        rise = -1;
        busy_low = 0;
        mask = 16'((32'd1 << nbits) - 1);
        set_in(id, 1'b1, d);
        @(negedge clk);
        set_in(id, 1'b0, d);
        for (int n = 0; n < explen + 40 && rise < 0; n++) begin
            if (get_done(id)) begin
                rise = n;
            end else begin
                if (!get_busy(id)) busy_low++;
                if ((n % bd) == bd / 2 && (n / bd) < nbits) got[n / bd] = get_tx(id);
                if (disturb) begin
                    if (n == 5) set_in(id, 1'b1, d);
                    else if (n == 40) set_in(id, 1'b1, 9'h0FF);
                    else set_in(id, 1'b0, (n > 40) ? 9'h0FF : d);
                end
                @(negedge clk);
            end
        end
        set_in(id, 1'b0, d);
        check_int("frame_bits", int'(got & mask), int'(expbits));
        check_int("done_latency", rise, explen);
        check_int("busy_low_in_frame", busy_low, 0);
        check_bit("busy_after_frame", id, get_busy(id), 1'b0);
        repeat (3) @(negedge clk);
        check_bit("done_sticky", id, get_done(id), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a, cnt_b;
        logic [8:0] rd;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            check_bit("reset_tx", id, get_tx(id), 1'b1);
            check_bit("reset_busy", id, get_busy(id), 1'b0);
            check_bit("reset_done", id, get_done(id), 1'b0);
        end
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (4) @(negedge clk);

        // Directed frames with hand-derived bit patterns.
        run_frame(0, 9'h0A5, 10, 16'h034A, 160, 1'b0);
        run_frame(1, 9'h041, 11, 16'h0682, 88, 1'b0);
        run_frame(2, 9'h000, 11, 16'h0700, 88, 1'b0);
        // Requests and data changes during a frame must not disturb it.
        run_frame(0, 9'h0A5, 10, 16'h034A, 160, 1'b1);

        // Reset in the middle of a frame.
        set_in(0, 1'b1, 9'h0A5);
        @(negedge clk);
        set_in(0, 1'b0, 9'h0A5);
        repeat (70) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_bit("midreset_tx", 0, tx0, 1'b1);
        check_bit("midreset_busy", 0, b0, 1'b0);
        check_bit("midreset_done", 0, dn0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cnt_a = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx0 !== 1'b1) cnt_a++;
        end
        check_int("post_reset_tx_low_cycles", cnt_a, 0);

        // trmt held high: frames back to back with one idle cycle between them.
        set_in(0, 1'b1, 9'($urandom_range(0, 255)));
        cnt_a = 0;
        cnt_b = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            set_in(0, 1'b1, 9'($urandom_range(0, 255)));
            if (dn0) cnt_a++;
            if (!b0) cnt_b++;
        end
        check_int("held_done_cycles", cnt_a, 2);
        check_int("held_idle_cycles", cnt_b, 2);
        check_bit("held_busy_at_400", 0, b0, 1'b1);
        set_in(0, 1'b0, 9'h000);
        cnt_a = 0;
        while (b0 && cnt_a < 300) begin
            @(negedge clk);
            cnt_a++;
        end
        check_bit("held_drained", 0, b0, 1'b0);

        // Random requests, data and occasional async resets on all instances.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int id = 0; id < 3; id++) begin
                rd = 9'($urandom_range(0, 511));
                set_in(id, ($urandom_range(0, 99) < 20), rd);
            end
            if ($urandom_range(0, 1499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        for (int id = 0; id < 3; id++) set_in(id, 1'b0, 9'h000);
        repeat (200) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter. It serialises one word per `trmt` strobe into a frame of start, data (LSB first), optional parity and stop bits. Data width, baud divisor, parity mode and stop-bit count are set at elaboration. It supersedes the fixed 8N1 transmitter and sits between the command/response logic and the serial line, paired with the receiver.

Parameters:
- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `BAUD_DIV`, default 2604: clk cycles per bit period; must be >= 2.
- `CNT_W`, default 12: baud counter width; must satisfy 2^CNT_W > BAUD_DIV.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `trmt`  in  1  single-cycle request to send `tx_data`.
- `tx_data`  in  `DATA_W`  word to transmit; sampled only on an accepted `trmt`.
- `TX`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  sticky completion flag.

Behaviour:
- Reset (async, `rst`=1): state=IDLE; `TX`=1; `busy`=0; `tx_done`=0; baud counter=0; bit counter=0; shift register all ones.
- All outputs are registered; `TX` is driven directly from a flop, glitch-free.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - `TX`=1, `busy`=0.
  - `trmt`=1 at a clk edge accepts the request: latch `tx_data` into the shift register and compute parity from the latched word.
  - Same edge: clear `tx_done`, set `busy`=1, enter START.
- START: `TX`=0 for `BAUD_DIV` cycles.
- DATA:
  - Bit i (i=0 first) is driven for `BAUD_DIV` cycles.
  - Shift right at each bit-period end.
  - Bit counter advances 0..`DATA_W`-1; exit after bit `DATA_W`-1.
- PARITY (only if `PARITY_EN`=1): `TX` = XOR of data bits, XOR `PARITY_ODD`, for `BAUD_DIV` cycles.
- STOP:
  - `TX`=1 for `STOP_BITS`*`BAUD_DIV` cycles.
  - At the end of the final stop period: `tx_done`=1, `busy`=0, state=IDLE, all on the same edge.
- Baud counter:
  - Counts 0..`BAUD_DIV`-1 while not IDLE; the terminal count marks the bit-period end and wraps to 0.
  - Forced to 0 on accept. Never free-runs in IDLE.
- Latency: accept at edge k gives `TX`=0 from edge k+1 (visible after edge k).
- Frame length: (1+`DATA_W`+`PARITY_EN`+`STOP_BITS`)*`BAUD_DIV` cycles from edge k to the edge that sets `tx_done`.
- `trmt` while `busy`=1: ignored. No queueing; `tx_data` changes have no effect on the frame in flight.
- `trmt` on the same cycle `busy` falls: still counts as busy and is ignored; a new request is accepted from the first IDLE cycle onward.
- Back-to-back: `trmt` on the first IDLE cycle gives a gap of exactly 1 clk of `TX`=1 beyond the stop bits.
- `tx_done`: stays 1 until the next accepted `trmt` or `rst`.
- Reset mid-frame: asynchronous abort; `TX` returns to 1 immediately and all other reset values apply. A partial frame is acceptable; no `tx_done`.
- `trmt` held high continuously: a new frame starts on every IDLE cycle; no edge detection is performed.

Test Plan:
- Defaults with `BAUD_DIV`=16, `rst` pulse then `trmt` with `tx_data`=8'hA5:
  - `TX` sequence, each bit held 16 cycles: 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` rises exactly 160 cycles after the accept edge; `busy` falls on the same edge.
- `DATA_W`=7, `PARITY_EN`=1, `PARITY_ODD`=0, `STOP_BITS`=2, `BAUD_DIV`=8, `tx_data`=7'h41:
  - Frame is 0, 1000001 LSB first, parity 0, then 1,1.
  - 11 bits = 88 cycles to `tx_done`.
- Same config with `PARITY_ODD`=1, `tx_data`=7'h00: parity bit=1.
- `trmt` pulsed at cycles 5 and 40 during a 160-cycle frame, with `tx_data` changed to 8'hFF at cycle 40:
  - Frame still carries 8'hA5.
  - Exactly one `tx_done` rise; `busy` stays 1 throughout.
- `rst` asserted at cycle 70 of a frame:
  - `TX`=1, `busy`=0, `tx_done`=0 before the next clk edge.
  - No further toggles on `TX` until a new `trmt`.
- `trmt` held high for 400 cycles (`BAUD_DIV`=16, 8N1):
  - Two complete frames separated by exactly 1 idle-high cycle; third frame in progress at cycle 400.
  - `tx_done` pulses high for 1 cycle between frames.
